// File: rtl/hub75_bcm_scanner_if.sv
// Bus bundle between the HUB75 scanner, the frame-buffer RAM and the panel pins.
// The scanner side uses the master modport; the RAM/panel side uses slave.
interface hub75_bcm_scanner_if #(
    parameter int ADDR_W     = 11,
    parameter int ROW_ADDR_W = 5
);
    logic [ADDR_W-1:0]     addr_out;
    logic                  rd_en;
    logic [15:0]           data_in_rgb0;
    logic [15:0]           data_in_rgb1;
    logic                  sclk;
    logic                  latch;
    logic                  OE;
    logic [1:0]            r_data;
    logic [1:0]            g_data;
    logic [1:0]            b_data;
    logic [ROW_ADDR_W-1:0] row_sel;
    logic                  frame_done;

    modport master (
        output addr_out, rd_en, sclk, latch, OE, r_data, g_data, b_data, row_sel, frame_done,
        input  data_in_rgb0, data_in_rgb1
    );

    modport slave (
        input  addr_out, rd_en, sclk, latch, OE, r_data, g_data, b_data, row_sel, frame_done,
        output data_in_rgb0, data_in_rgb1
    );
endinterface

// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel scanner with binary-code-modulated colour depth.
// Shifts row N+1 out of the frame RAM while row N is displayed; planes are
// scanned MSB first, each plane shown for BASE_PERIOD<<p ticks.
// Optional feature macro: HUB75_BRIGHTNESS_EN adds a brightness[7:0] input that
// shortens the OE-low part of each display period (period length unchanged).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | blanked, waiting for enable and an expired display timer
// SHIFT   | per column: read RAM (phase A), then raise sclk (phase B)
// WAIT    | row shifted, waiting for the previous row's period to end
// BLANK   | force OE high before latching
// LATCH   | latch high, row_sel takes the freshly shifted row
// UNLATCH | latch low
// SHOW    | OE low, load display timer, advance row/plane
module hub75_bcm_scanner #(
    parameter int COLS        = 64,
    parameter int ROW_ADDR_W  = 5,
    parameter int BPC         = 5,
    parameter int BASE_PERIOD = 8,
    parameter int PRESCALER   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0] brightness,
`endif
    hub75_bcm_scanner_if.master bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(COLS + 1);
    localparam int PL_W  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int TMR_W = $clog2(BASE_PERIOD << (BPC - 1)) + 1;
    localparam int PS_W  = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
    localparam int R_LSB = 16 - BPC;
    localparam int G_LSB = 11 - BPC;
    localparam int B_LSB = 5 - BPC;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_BLANK   = 3'd3;
    localparam logic [2:0] S_LATCH   = 3'd4;
    localparam logic [2:0] S_UNLATCH = 3'd5;
    localparam logic [2:0] S_SHOW    = 3'd6;

    logic [2:0]            r_state;
    logic [PS_W-1:0]       r_pre;
    logic [ROW_ADDR_W-1:0] r_row;       // row being shifted / next to latch
    logic [PL_W-1:0]       r_plane;     // plane being shifted / next to latch
    logic [CNT_W-1:0]      r_col;
    logic                  r_phase_b;
    logic                  r_cap;
    logic                  r_data_ok;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      r_on_cnt;
    logic [ROW_ADDR_W+COL_W-1:0] r_addr;
    logic                  r_rd_en;
    logic                  r_sclk;
    logic                  r_latch;
    logic                  r_oe;
    logic [1:0]            r_red;
    logic [1:0]            r_grn;
    logic [1:0]            r_blu;
    logic [ROW_ADDR_W-1:0] r_row_sel;
    logic                  r_frame_done;

    logic                  w_tick;
    logic [3:0]            w_ridx;
    logic [3:0]            w_gidx;
    logic [3:0]            w_bidx;
    logic [TMR_W-1:0]      w_period;
    logic [TMR_W-1:0]      w_on_len;

    assign w_tick   = (r_pre == PS_W'(PRESCALER));
    assign w_ridx   = 4'(R_LSB) + 4'(r_plane);
    assign w_gidx   = 4'(G_LSB) + 4'(r_plane);
    assign w_bidx   = 4'(B_LSB) + 4'(r_plane);
    assign w_period = TMR_W'(BASE_PERIOD) << r_plane;

`ifdef HUB75_BRIGHTNESS_EN
    logic [TMR_W+8:0] w_prod;
    assign w_prod   = {9'd0, w_period} * {{TMR_W{1'b0}}, ({1'b0, brightness} + 9'd1)};
    assign w_on_len = w_prod[TMR_W+7:8];
`else
    assign w_on_len = w_period;
`endif

    // Tick generator: one tick every PRESCALER+1 clocks.
    always_ff @(posedge clk) begin
        if (rst || w_tick) r_pre <= '0;
        else               r_pre <= r_pre + PS_W'(1);
    end

    // Scan FSM, RAM read pipeline, display timers and all registered panel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_plane      <= PL_W'(BPC - 1);
            r_col        <= '0;
            r_phase_b    <= 1'b0;
            r_cap        <= 1'b0;
            r_data_ok    <= 1'b0;
            r_timer      <= '0;
            r_on_cnt     <= '0;
            r_addr       <= '0;
            r_rd_en      <= 1'b0;
            r_sclk       <= 1'b0;
            r_latch      <= 1'b0;
            r_oe         <= 1'b1;
            r_red        <= '0;
            r_grn        <= '0;
            r_blu        <= '0;
            r_row_sel    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            // RAM data is valid the clock after the read strobe was seen.
            r_cap        <= r_rd_en;
            if (r_cap) begin
                r_red     <= {bus.data_in_rgb1[w_ridx], bus.data_in_rgb0[w_ridx]};
                r_grn     <= {bus.data_in_rgb1[w_gidx], bus.data_in_rgb0[w_gidx]};
                r_blu     <= {bus.data_in_rgb1[w_bidx], bus.data_in_rgb0[w_bidx]};
                r_data_ok <= 1'b1;
            end
            if (w_tick) begin
                if (r_timer != '0) r_timer <= r_timer - TMR_W'(1);
                // OE goes dark on the tick its on-time expires, independent of the FSM.
                if (r_on_cnt != '0) begin
                    r_on_cnt <= r_on_cnt - TMR_W'(1);
                    if (r_on_cnt == TMR_W'(1)) r_oe <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (enable && r_timer == '0) begin
                            r_state   <= S_SHIFT;
                            r_col     <= '0;
                            r_phase_b <= 1'b0;
                        end
                    end
                    S_SHIFT: begin
                        if (!r_phase_b) begin
                            if (r_col == CNT_W'(COLS)) begin
                                r_sclk  <= 1'b0;
                                r_state <= S_WAIT;
                            end else begin
                                r_rd_en   <= 1'b1;
                                r_addr    <= {r_row, r_col[COL_W-1:0]};
                                r_sclk    <= 1'b0;
                                r_data_ok <= 1'b0;
                                r_phase_b <= 1'b1;
                            end
                        end else if (r_data_ok) begin
                            // Rising edge only once the column data has settled on the pins.
                            r_sclk    <= 1'b1;
                            r_col     <= r_col + CNT_W'(1);
                            r_phase_b <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (r_timer == '0) r_state <= S_BLANK;
                    end
                    S_BLANK: begin
                        r_oe    <= 1'b1;
                        r_state <= S_LATCH;
                    end
                    S_LATCH: begin
                        r_latch   <= 1'b1;
                        r_row_sel <= r_row;
                        if ((&r_row) && r_plane == '0) r_frame_done <= 1'b1;
                        r_state   <= S_UNLATCH;
                    end
                    S_UNLATCH: begin
                        r_latch <= 1'b0;
                        r_state <= S_SHOW;
                    end
                    S_SHOW: begin
                        r_timer   <= w_period;
                        r_on_cnt  <= w_on_len;
                        r_oe      <= (w_on_len == '0);
                        r_row     <= r_row + ROW_ADDR_W'(1);
                        if (&r_row) begin
                            if (r_plane == '0) r_plane <= PL_W'(BPC - 1);
                            else               r_plane <= r_plane - PL_W'(1);
                        end
                        r_col     <= '0;
                        r_phase_b <= 1'b0;
                        r_state   <= enable ? S_SHIFT : S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.addr_out   = r_addr;
    assign bus.rd_en      = r_rd_en;
    assign bus.sclk       = r_sclk;
    assign bus.latch      = r_latch;
    assign bus.OE         = r_oe;
    assign bus.r_data     = r_red;
    assign bus.g_data     = r_grn;
    assign bus.b_data     = r_blu;
    assign bus.row_sel    = r_row_sel;
    assign bus.frame_done = r_frame_done;
endmodule
